// File: rtl/datamem_arbiter_if.sv
// Requester-side bus of the data-RAM arbiter: port 0 (MEM stage) and port 1 (loader/debug).
// master = requester side, slave = arbiter side.
interface datamem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     m0_req;
  logic                     m0_we;
  logic [ADDRESS_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0]    m0_wdata;
  logic                     m0_gnt;
  logic                     m0_rvalid;
  logic [DATA_WIDTH-1:0]    m0_rdata;

  logic                     m1_req;
  logic                     m1_we;
  logic [ADDRESS_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0]    m1_wdata;
  logic                     m1_lock;
  logic                     m1_gnt;
  logic                     m1_rvalid;
  logic [DATA_WIDTH-1:0]    m1_rdata;

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata
  );

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata
  );
endinterface

// File: rtl/datamem_arbiter.sv
// Fixed-priority arbiter sharing one single-port data RAM; port 1 may lock it for bursts.
// Grants combinational, read data registered (1 cycle). Optional port-1 aging: DMEM_ARB_AGING_EN.
module datamem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  datamem_arbiter_if.slave         bus,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic {
    IDLE  = 1'b0,
    LOCK1 = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   m0_gnt, m1_gnt;
  logic   m1_prio;

`ifdef DMEM_ARB_AGING_EN
  localparam logic [7:0] MAX_WAIT_W = 8'(MAX_WAIT);
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (m1_gnt || !bus.m1_req) begin
      wait_cnt <= 8'd0;
    end else if (state == IDLE && wait_cnt != MAX_WAIT_W) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign m1_prio = (wait_cnt == MAX_WAIT_W);
`else
  assign m1_prio = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Grants are held low during reset so no RAM write can slip through mid-reset.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    state_nxt = state;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (bus.m1_req && m1_prio) m1_gnt = 1'b1;
          else if (bus.m0_req)       m0_gnt = 1'b1;
          else if (bus.m1_req)       m1_gnt = 1'b1;
          if (m1_gnt && bus.m1_lock) state_nxt = LOCK1;
        end
        LOCK1: begin
          m1_gnt = bus.m1_req;
          // Dropping lock ends the burst whether or not this cycle carries an access.
          if (!bus.m1_lock) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.m0_gnt = m0_gnt;
  assign bus.m1_gnt = m1_gnt;

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (m0_gnt) begin
      mem_we = bus.m0_we;
      mem_a  = bus.m0_addr;
      mem_wd = bus.m0_wdata;
    end else if (m1_gnt) begin
      mem_we = bus.m1_we;
      mem_a  = bus.m1_addr;
      mem_wd = bus.m1_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m0_rvalid <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rvalid <= 1'b0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.m0_rvalid <= m0_gnt && !bus.m0_we;
      bus.m1_rvalid <= m1_gnt && !bus.m1_we;
      if (m0_gnt && !bus.m0_we) bus.m0_rdata <= mem_rd;
      if (m1_gnt && !bus.m1_we) bus.m1_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter: vector table plus reset-mid-lock and aging sequences.
module tb_datamem_arbiter;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] AA = 32'h5A5A5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [31:0] ram [0:4095];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  datamem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  datamem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus.slave),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  // Test addresses (0x10, 0x20, 0x10000..0x10003) do not alias in the low 12 bits.
  assign mem_rd = ram[mem_a[11:0]];
  always @(posedge clk) if (mem_we) ram[mem_a[11:0]] <= mem_wd;

  typedef struct {
    logic        m0_req, m0_we;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_we, m1_lock;
    logic [31:0] m1_addr, m1_wdata;
    logic        g0, g1, mwe;
    logic [31:0] ma, mwd;
    logic        rv0;
    logic [31:0] rd0;
    logic        rv1;
    logic [31:0] rd1;
  } vec_t;

  vec_t vec [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic l1, input logic [31:0] a1,
                       input logic [31:0] d1);
    bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
    bus.m1_req = r1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;

    //          m0: req we addr wdata     m1: req we lock addr wdata   exp: g0 g1 mwe ma mwd   rv0 rd0 rv1 rd1
    vec[0]  = '{T,T,32'h10,DB,            F,F,F,Z,Z,                   T,F,T,32'h10,DB,        F,Z,F,Z};
    vec[1]  = '{T,F,32'h10,Z,             F,F,F,Z,Z,                   T,F,F,32'h10,Z,         T,DB,F,Z};
    vec[2]  = '{F,F,Z,Z,                  F,F,F,Z,Z,                   F,F,F,Z,Z,              F,DB,F,Z};
    vec[3]  = '{T,F,32'h10,Z,             T,F,F,32'h10,Z,              T,F,F,32'h10,Z,         T,DB,F,Z};
    vec[4]  = '{F,F,Z,Z,                  T,F,F,32'h10,Z,              F,T,F,32'h10,Z,         F,DB,T,DB};
    vec[5]  = '{F,F,Z,Z,                  T,T,F,32'h20,AA,             F,T,T,32'h20,AA,        F,DB,F,DB};
    vec[6]  = '{T,F,32'h20,Z,             F,F,F,Z,Z,                   T,F,F,32'h20,Z,         T,AA,F,DB};
    vec[7]  = '{F,F,Z,Z,                  T,T,T,32'h10000,32'd1,       F,T,T,32'h10000,32'd1,  F,AA,F,DB};
    vec[8]  = '{T,F,32'h10,Z,             T,T,T,32'h10001,32'd2,       F,T,T,32'h10001,32'd2,  F,AA,F,DB};
    vec[9]  = '{T,F,32'h10,Z,             T,T,T,32'h10002,32'd3,       F,T,T,32'h10002,32'd3,  F,AA,F,DB};
    vec[10] = '{T,F,32'h10,Z,             T,T,F,32'h10003,32'd4,       F,T,T,32'h10003,32'd4,  F,AA,F,DB};
    vec[11] = '{T,F,32'h10,Z,             F,F,F,Z,Z,                   T,F,F,32'h10,Z,         T,DB,F,DB};
    vec[12] = '{F,F,Z,Z,                  T,F,T,32'h20,Z,              F,T,F,32'h20,Z,         F,DB,T,AA};
    vec[13] = '{T,F,32'h10,Z,             F,F,T,Z,Z,                   F,F,F,Z,Z,              F,DB,F,AA};
    vec[14] = '{T,F,32'h10,Z,             F,F,F,Z,Z,                   F,F,F,Z,Z,              F,DB,F,AA};
    vec[15] = '{T,F,32'h10,Z,             F,F,F,Z,Z,                   T,F,F,32'h10,Z,         T,DB,F,AA};

    rst = 1'b1;
    drive(F, F, Z, Z, F, F, F, Z, Z);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_m0_rvalid", 32'(bus.m0_rvalid), Z);
    chk("reset_m1_rvalid", 32'(bus.m1_rvalid), Z);
    chk("reset_m0_rdata", bus.m0_rdata, Z);
    chk("reset_m1_rdata", bus.m1_rdata, Z);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vec[i].m0_req, vec[i].m0_we, vec[i].m0_addr, vec[i].m0_wdata,
            vec[i].m1_req, vec[i].m1_we, vec[i].m1_lock, vec[i].m1_addr, vec[i].m1_wdata);
      #1;
      chk($sformatf("v%0d_m0_gnt", i), 32'(bus.m0_gnt), 32'(vec[i].g0));
      chk($sformatf("v%0d_m1_gnt", i), 32'(bus.m1_gnt), 32'(vec[i].g1));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vec[i].mwe));
      chk($sformatf("v%0d_mem_a", i), mem_a, vec[i].ma);
      chk($sformatf("v%0d_mem_wd", i), mem_wd, vec[i].mwd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_m0_rvalid", i), 32'(bus.m0_rvalid), 32'(vec[i].rv0));
      chk($sformatf("v%0d_m0_rdata", i), bus.m0_rdata, vec[i].rd0);
      chk($sformatf("v%0d_m1_rvalid", i), 32'(bus.m1_rvalid), 32'(vec[i].rv1));
      chk($sformatf("v%0d_m1_rdata", i), bus.m1_rdata, vec[i].rd1);
    end

    for (int k = 0; k < 4; k++) chk($sformatf("ram_burst_%0d", k), ram[k], 32'(k + 1));
    chk("ram_0x20", ram[12'h20], AA);

    // Reset asserted in the middle of a locked read burst.
    @(negedge clk);
    drive(F, F, Z, Z, T, F, T, 32'h10000, Z);
    @(posedge clk);
    @(negedge clk);
    drive(T, F, 32'h10, Z, T, F, T, 32'h10001, Z);
    #1;
    chk("lock_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    chk("lock_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("lock_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
    chk("lock_m1_rdata", bus.m1_rdata, 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    chk("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    chk("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    chk("rst_m1_rdata", bus.m1_rdata, Z);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    chk("post_rst_m1_gnt", 32'(bus.m1_gnt), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    chk("post_rst_m0_rdata", bus.m0_rdata, DB);

    // Idle cycle so any wait count starts from zero.
    @(negedge clk);
    drive(F, F, Z, Z, F, F, F, Z, Z);
    @(posedge clk);

    // Both ports requesting reads continuously for 100 cycles.
    @(negedge clk);
    drive(T, F, 32'h10, Z, T, F, F, 32'h20, Z);
    for (int n = 1; n <= 100; n++) begin
      logic exp_g1;
`ifdef DMEM_ARB_AGING_EN
      exp_g1 = (n % 9 == 0);
`else
      exp_g1 = 1'b0;
`endif
      #1;
      chk($sformatf("age%0d_m1_gnt", n), 32'(bus.m1_gnt), 32'(exp_g1));
      chk($sformatf("age%0d_m0_gnt", n), 32'(bus.m0_gnt), 32'(!exp_g1));
      @(posedge clk);
      #1;
      chk($sformatf("age%0d_m1_rvalid", n), 32'(bus.m1_rvalid), 32'(exp_g1));
      @(negedge clk);
    end
    drive(F, F, Z, Z, F, F, F, Z, Z);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Two-port arbiter that shares the single-port data RAM (combinational read, write on posedge clk) between two requesters.
- Port 0 is the pipeline MEM stage; port 1 is the loader/debug port that preloads or inspects data memory.
- Arbitration is fixed priority: port 0 wins by default.
- Port 1 can lock the RAM for a burst.
- Read data is returned registered, one cycle after grant.

Parameters:
- ADDRESS_WIDTH, 32, width of the word address driven to the RAM.
- DATA_WIDTH, 32, width of the data words.
- MAX_WAIT, 8, cycles port 1 may be denied before aging forces a grant. Used only with DMEM_ARB_AGING_EN; 1..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write enable (1 = write, 0 = read).
- m0_addr  in  ADDRESS_WIDTH  port 0 address.
- m0_wdata  in  DATA_WIDTH  port 0 write data.
- m0_gnt  out  1  port 0 granted this cycle (combinational).
- m0_rvalid  out  1  port 0 read data valid (registered).
- m0_rdata  out  DATA_WIDTH  port 0 read data (registered).
- m1_req, m1_we, m1_addr, m1_wdata  in  same widths as port 0  port 1 request.
- m1_lock  in  1  keep ownership after this granted access.
- m1_gnt  out  1  port 1 granted this cycle.
- m1_rvalid  out  1  port 1 read data valid.
- m1_rdata  out  DATA_WIDTH  port 1 read data.
- mem_we  out  1  RAM write enable.
- mem_a  out  ADDRESS_WIDTH  RAM address.
- mem_wd  out  DATA_WIDTH  RAM write data.
- mem_rd  in  DATA_WIDTH  RAM combinational read data.

Behaviour:
- Reset:
  - State = IDLE; wait counter = 0.
  - m0_rvalid = m1_rvalid = 0; m0_rdata = m1_rdata = 0.
  - Reset applies immediately and asynchronously, including mid-lock.
- Grants are combinational:
  - At most one of m0_gnt/m1_gnt is high.
  - A grant is never asserted without the matching req.
- State IDLE:
  - m0_req → m0 granted.
  - Else m1_req → m1 granted.
  - Neither → no grant.
  - If m1 is granted with m1_lock=1 → next state LOCK1.
- State LOCK1:
  - m0_gnt is forced 0; m1 is granted whenever m1_req=1.
  - Leave to IDLE on the edge where either:
    - m1 is granted with m1_lock=0, or
    - m1_req=0 and m1_lock=0.
  - m1_req=0 with m1_lock=1 holds LOCK1 with the RAM idle.
- RAM mux:
  - mem_a and mem_wd come from the granted port.
  - mem_we = granted port's we.
  - With no grant: mem_we=0, mem_a=0, mem_wd=0.
- Writes: commit at the grant edge; no response pulse.
- Reads:
  - At the grant edge, rdata of the granted port <= mem_rd.
  - That port's rvalid = 1 for exactly one cycle.
  - Latency is one cycle.
- rdata holds its last value until the next granted read on that port.
  - rvalid is 0 otherwise.
  - A write grant clears that port's rvalid for the next cycle.
- Back-to-back: a port may be granted on consecutive cycles; each read gives its own rvalid pulse.
- Read-after-write to the same address on consecutive grants returns the new data.
- A requester holds req, we, addr and wdata stable until it sees gnt. An ungranted request is not consumed.

Optional Feature:
- Macro: DMEM_ARB_AGING_EN.
- Defined:
  - An 8-bit wait counter increments each cycle m1_req=1 && m1_gnt=0 in IDLE, saturating at MAX_WAIT.
  - While counter == MAX_WAIT, m1 beats m0 in IDLE.
  - The counter clears on any m1 grant and whenever m1_req=0.
- Undefined: strict priority; port 1 may starve indefinitely. No counter logic is present.

Test Plan:
- Reset, then m0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 → m0_gnt both cycles; m0_rvalid=1 and m0_rdata=0xDEADBEEF one cycle after the read grant.
- m0_req and m1_req both high in IDLE, both reads → m0_gnt=1, m1_gnt=0; m1 granted the first cycle m0_req drops; m1_rvalid follows one cycle later.
- m1 burst of 4 writes to 0x10000–0x10003 (values 1–4) with m1_lock=1 on the first three, m0_req held high throughout → m0_gnt=0 for all 4 cycles; m0 granted the cycle after the burst; RAM holds 1–4.
- Assert rst mid-lock (after the 2nd burst write) → m1_gnt and rvalids drop immediately; after release, m0_req is granted in IDLE.
- With DMEM_ARB_AGING_EN and MAX_WAIT=8: m0_req high continuously, m1_req high → m1 granted on the 9th cycle of waiting, then m0 wins again. Without the macro, m1 is never granted over 100 cycles.
- Read-after-write: m1 writes 0x5A5A5A5A to 0x20, m0 reads 0x20 the next cycle → m0_rdata=0x5A5A5A5A; the write itself produces no m1_rvalid pulse.
